// File: rtl/eth_tx_scheduler.sv
// eth_tx_scheduler
//   Shares the byte-wide TX FIFO of ethernet_with_fifos between NREQ packet
//   sources. Whole packets are arbitrated round-robin. For each packet the
//   block writes a 16-bit big-endian length header and then the payload. It
//   recovers cleanly when the FIFO signals tx_reset.
//
// Parameters
//   NREQ     number of requesters (1..4)
//   MAX_LEN  largest legal payload length in bytes
//
// Ports
//   clk_i, rst_i    clock, asynchronous active-high reset
//   req_i           per-requester packet pending (held until done/err/abort)
//   req_len_i       per-requester payload length, slice n = [16n+15:16n]
//   data_valid_i    per-requester payload byte valid
//   data_i          per-requester payload byte, slice n = [8n+7:8n]
//   data_ready_o    per-requester byte accepted this cycle
//   grant_o         one-hot current owner, 0 when idle
//   done_o          1-cycle pulse: packet fully written
//   err_o           1-cycle pulse: illegal length, nothing written
//   abort_o         1-cycle pulse: packet lost to FIFO tx_reset
//   tx_data_o       byte to the FIFO
//   tx_wr_en_o      FIFO write strobe
//   tx_full_i       FIFO full
//   tx_reset_i      FIFO reset in progress
//
// Optional build macro ETH_TX_SCHED_STATS_EN adds the following outputs:
//   stat_pkts_o     [31:0] count of completed packets (all requesters)
//   stat_aborts_o   [15:0] count of aborted packets
module eth_tx_scheduler #(
  parameter int NREQ    = 2,
  parameter int MAX_LEN = 1518
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NREQ-1:0]     req_i,
  input  logic [16*NREQ-1:0]  req_len_i,
  input  logic [NREQ-1:0]     data_valid_i,
  input  logic [8*NREQ-1:0]   data_i,
  output logic [NREQ-1:0]     data_ready_o,
  output logic [NREQ-1:0]     grant_o,
  output logic [NREQ-1:0]     done_o,
  output logic [NREQ-1:0]     err_o,
  output logic [NREQ-1:0]     abort_o,
  output logic [7:0]          tx_data_o,
  output logic                tx_wr_en_o,
  input  logic                tx_full_i,
  input  logic                tx_reset_i
`ifdef ETH_TX_SCHED_STATS_EN
  ,
  output logic [31:0]         stat_pkts_o,
  output logic [15:0]         stat_aborts_o
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_HDR_HI, S_HDR_LO, S_DATA, S_WAIT_RST
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   rr_q;
  logic [IW-1:0]   gidx_q;
  logic [15:0]     len_q;
  logic [15:0]     cnt_q;

  logic [IW-1:0]   pick_idx;
  logic            pick_vld;
  logic [NREQ-1:0] pick_onehot;
  logic [IW-1:0]   next_rr;
  logic            fifo_ok;
  logic [7:0]      gdata;
  logic            gvalid;
  int              cand;

  function automatic logic len_bad(input logic [15:0] len);
    return (len == 16'd0) || (len > 16'(MAX_LEN));
  endfunction

  // Round-robin pick: scan from rr_q upward with wrap. The scan runs from
  // the farthest candidate down so that the nearest requester wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = int'(rr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (req_i[cand]) begin
        pick_vld = 1'b1;
        pick_idx = IW'(cand);
      end
    end
    for (int k = 0; k < NREQ; k++) pick_onehot[k] = (pick_idx == IW'(k));
  end

  assign next_rr = (int'(gidx_q) == NREQ - 1) ? '0 : gidx_q + 1'b1;
  assign fifo_ok = !tx_full_i && !tx_reset_i;
  assign gdata   = data_i[gidx_q*8 +: 8];
  assign gvalid  = data_valid_i[gidx_q];

  // FIFO-side write path is combinational so a full/reset blocks the write in
  // the very cycle it appears, which allows back-to-back bytes without bubbles.
  always_comb begin
    tx_wr_en_o   = 1'b0;
    tx_data_o    = 8'h00;
    data_ready_o = '0;
    case (state_q)
      S_HDR_HI: begin
        tx_data_o  = len_q[15:8];
        tx_wr_en_o = fifo_ok;
      end
      S_HDR_LO: begin
        tx_data_o  = len_q[7:0];
        tx_wr_en_o = fifo_ok;
      end
      S_DATA: begin
        tx_data_o            = gdata;
        data_ready_o[gidx_q] = fifo_ok;
        tx_wr_en_o           = fifo_ok && gvalid;
      end
      default: ;
    endcase
  end

  // Control FSM and registered status pulses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      gidx_q  <= '0;
      grant_o <= '0;
      done_o  <= '0;
      err_o   <= '0;
      abort_o <= '0;
    end else begin
      done_o  <= '0;
      err_o   <= '0;
      abort_o <= '0;
      case (state_q)
        S_IDLE: begin
          if (tx_reset_i) begin
            state_q <= S_WAIT_RST;
          end else if (pick_vld) begin
            gidx_q  <= pick_idx;
            grant_o <= pick_onehot;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (tx_reset_i) begin
            abort_o[gidx_q] <= 1'b1;
            grant_o         <= '0;
            rr_q            <= next_rr;
            state_q         <= S_WAIT_RST;
          end else if (len_bad(len_q)) begin
            err_o[gidx_q] <= 1'b1;
            grant_o       <= '0;
            rr_q          <= next_rr;
            state_q       <= S_IDLE;
          end else begin
            state_q <= S_HDR_HI;
          end
        end
        S_HDR_HI, S_HDR_LO, S_DATA: begin
          if (tx_reset_i) begin
            abort_o[gidx_q] <= 1'b1;
            grant_o         <= '0;
            rr_q            <= next_rr;
            state_q         <= S_WAIT_RST;
          end else if (state_q == S_HDR_HI) begin
            if (!tx_full_i) state_q <= S_HDR_LO;
          end else if (state_q == S_HDR_LO) begin
            if (!tx_full_i) state_q <= S_DATA;
          end else if (tx_wr_en_o && cnt_q == 16'd1) begin
            done_o[gidx_q] <= 1'b1;
            grant_o        <= '0;
            rr_q           <= next_rr;
            state_q        <= S_IDLE;
          end
        end
        S_WAIT_RST: begin
          if (!tx_reset_i && !tx_full_i) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Length capture and payload down-counter; always loaded before use
  always_ff @(posedge clk_i) begin
    if (state_q == S_IDLE && !tx_reset_i && pick_vld)
      len_q <= req_len_i[pick_idx*16 +: 16];
    if (state_q == S_CHECK)
      cnt_q <= len_q;
    else if (state_q == S_DATA && tx_wr_en_o)
      cnt_q <= cnt_q - 16'd1;
  end

`ifdef ETH_TX_SCHED_STATS_EN
  // Counters follow the registered pulses, so they move one cycle after them
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_pkts_o   <= '0;
      stat_aborts_o <= '0;
    end else begin
      if (|done_o)  stat_pkts_o   <= stat_pkts_o + 32'd1;
      if (|abort_o) stat_aborts_o <= stat_aborts_o + 16'd1;
    end
  end
`else
`endif

endmodule

// File: tb/tb_eth_tx_scheduler.sv
// Directed testbench for eth_tx_scheduler (NREQ=2, MAX_LEN=1518).
// The bench models two requesters as byte queues. A negedge monitor logs
// every FIFO write and status pulse. Each scenario compares these logs
// against hand-built expected sequences.
module tb_eth_tx_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  req_i;
  logic [31:0] req_len_i;
  logic [1:0]  data_valid_i;
  logic [15:0] data_i;
  logic [1:0]  data_ready_o, grant_o, done_o, err_o, abort_o;
  logic [7:0]  tx_data_o;
  logic        tx_wr_en_o, tx_full_i, tx_reset_i;
`ifdef ETH_TX_SCHED_STATS_EN
  logic [31:0] stat_pkts_o;
  logic [15:0] stat_aborts_o;
`endif

  always #5 clk_i = ~clk_i;

  eth_tx_scheduler #(.NREQ(2), .MAX_LEN(1518)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .req_len_i(req_len_i),
    .data_valid_i(data_valid_i), .data_i(data_i), .data_ready_o(data_ready_o),
    .grant_o(grant_o), .done_o(done_o), .err_o(err_o), .abort_o(abort_o),
    .tx_data_o(tx_data_o), .tx_wr_en_o(tx_wr_en_o), .tx_full_i(tx_full_i),
    .tx_reset_i(tx_reset_i)
`ifdef ETH_TX_SCHED_STATS_EN
    , .stat_pkts_o(stat_pkts_o), .stat_aborts_o(stat_aborts_o)
`endif
  );

  int checks = 0;
  int errors = 0;
  int viol   = 0;
  int cyc    = 0;
  logic [7:0] src0[$], src1[$], wr_q[$], exp_q[$];
  int         wrc_q[$];
  logic [1:0] done_q[$], err_q[$], abort_q[$];
  logic [1:0] pop = 2'b00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    data_valid_i[0] = req_i[0] && (src0.size() > 0);
    data_valid_i[1] = req_i[1] && (src1.size() > 0);
    data_i[7:0]     = (src0.size() > 0) ? src0[0] : 8'h00;
    data_i[15:8]    = (src1.size() > 0) ? src1[0] : 8'h00;
  endtask

  task automatic drop(input int n);
    req_i[n] = 1'b0;
    pop[n]   = 1'b0;
    if (n == 0) src0.delete(); else src1.delete();
    drive();
  endtask

  task automatic sync();
    @(posedge clk_i); #3;
  endtask

  task automatic start_pkt(input int n, input logic [15:0] len, input logic [7:0] base, input int nb);
    req_len_i[16*n +: 16] = len;
    for (int i = 0; i < nb; i++) begin
      if (n == 0) src0.push_back(base + 8'(i)); else src1.push_back(base + 8'(i));
    end
    req_i[n] = 1'b1;
    drive();
  endtask

  task automatic exp_pkt(input logic [15:0] len, input logic [7:0] base, input int nb);
    exp_q.push_back(len[15:8]);
    exp_q.push_back(len[7:0]);
    for (int i = 0; i < nb; i++) exp_q.push_back(base + 8'(i));
  endtask

  task automatic clear_logs();
    wr_q.delete(); wrc_q.delete(); exp_q.delete();
    done_q.delete(); err_q.delete(); abort_q.delete();
  endtask

  task automatic cmp_wr(input string tag);
    chk({tag, "_nwr"}, 32'(wr_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk({tag, "_byte"}, (i < wr_q.size()) ? 32'(wr_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (req_i != 2'b00 && k < 300) begin sync(); k++; end
    chk({tag, "_idle"}, 32'(req_i == 2'b00), 32'd1);
    if (req_i != 2'b00) begin drop(0); drop(1); end
    sync(); sync();
  endtask

  task automatic wait_wr(input string tag, input int n);
    int k = 0;
    while (wr_q.size() < n && k < 300) begin @(posedge clk_i); #2; k++; end
    chk({tag, "_wrcnt"}, 32'(wr_q.size() >= n), 32'd1);
  endtask

  // Consumer of the payload pops that the monitor flagged
  always @(posedge clk_i) begin
    #1;
    if (pop[0] && src0.size() > 0) void'(src0.pop_front());
    if (pop[1] && src1.size() > 0) void'(src1.pop_front());
    pop = 2'b00;
    drive();
  end

  // Monitor: observe the settled pre-edge values
  always @(negedge clk_i) begin
    cyc++;
    if (!rst_i) begin
      if (tx_wr_en_o) begin
        wr_q.push_back(tx_data_o);
        wrc_q.push_back(cyc);
        if (tx_full_i || tx_reset_i || grant_o == 2'b00) viol++;
      end
      if ((tx_full_i || tx_reset_i) && data_ready_o != 2'b00) viol++;
      if ((data_ready_o & ~grant_o) != 2'b00) viol++;
      if ($countones(grant_o) > 1) viol++;
      if (int'(|done_o) + int'(|err_o) + int'(|abort_o) > 1) viol++;
      if (|done_o)  done_q.push_back(done_o);
      if (|err_o)   err_q.push_back(err_o);
      if (|abort_o) abort_q.push_back(abort_o);
      for (int n = 0; n < 2; n++) begin
        if (done_o[n] || err_o[n] || abort_o[n]) drop(n);
        else if (data_ready_o[n] && data_valid_i[n]) pop[n] = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; req_i = 2'b00; req_len_i = '0; data_valid_i = 2'b00; data_i = '0;
    tx_full_i = 1'b0; tx_reset_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #2;
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_wren", 32'(tx_wr_en_o), 32'd0);
    chk("rst_pulses", 32'({done_o, err_o, abort_o}), 32'd0);
    chk("rst_ready", 32'(data_ready_o), 32'd0);
    rst_i = 1'b0;
    sync();

    // Single packet, FIFO never full
    clear_logs();
    start_pkt(0, 16'd3, 8'hA1, 3);
    wait_idle("t1");
    exp_pkt(16'd3, 8'hA1, 3);
    cmp_wr("t1");
    chk("t1_consec", (wrc_q.size() >= 5) ? 32'(wrc_q[4] - wrc_q[0]) : 32'hFFFF_FFFF, 32'd4);
    chk("t1_ndone", 32'(done_q.size()), 32'd1);
    chk("t1_done", (done_q.size() > 0) ? 32'(done_q[0]) : 32'hF, 32'h1);

    // Illegal lengths on requester 1
    clear_logs();
    start_pkt(1, 16'd0, 8'h00, 0);
    wait_idle("t3a");
    start_pkt(1, 16'd1519, 8'hE0, 2);
    wait_idle("t3b");
    chk("t3_nerr", 32'(err_q.size()), 32'd2);
    chk("t3_err0", (err_q.size() > 0) ? 32'(err_q[0]) : 32'hF, 32'h2);
    chk("t3_err1", (err_q.size() > 1) ? 32'(err_q[1]) : 32'hF, 32'h2);
    chk("t3_nwr", 32'(wr_q.size()), 32'd0);
    chk("t3_ndone", 32'(done_q.size()), 32'd0);

    // Simultaneous pair with rr back at 0 -> req0 first
    clear_logs();
    start_pkt(0, 16'd2, 8'h10, 2);
    start_pkt(1, 16'd2, 8'h20, 2);
    wait_idle("t2a");
    exp_pkt(16'd2, 8'h10, 2);
    exp_pkt(16'd2, 8'h20, 2);
    cmp_wr("t2a");
    chk("t2a_done0", (done_q.size() > 0) ? 32'(done_q[0]) : 32'hF, 32'h1);
    chk("t2a_done1", (done_q.size() > 1) ? 32'(done_q[1]) : 32'hF, 32'h2);

    // req0 alone moves rr to 1, then the next pair starts with req1
    clear_logs();
    start_pkt(0, 16'd1, 8'h05, 1);
    wait_idle("t2b0");
    start_pkt(0, 16'd2, 8'h12, 2);
    start_pkt(1, 16'd2, 8'h22, 2);
    wait_idle("t2b");
    exp_pkt(16'd1, 8'h05, 1);
    exp_pkt(16'd2, 8'h22, 2);
    exp_pkt(16'd2, 8'h12, 2);
    cmp_wr("t2b");
    chk("t2b_done1", (done_q.size() > 1) ? 32'(done_q[1]) : 32'hF, 32'h2);

    // FIFO full for 4 cycles before payload byte 5 of 10
    clear_logs();
    start_pkt(0, 16'd10, 8'h30, 10);
    wait_wr("t4", 6);
    tx_full_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #2 tx_full_i = 1'b0;
    wait_idle("t4");
    exp_pkt(16'd10, 8'h30, 10);
    cmp_wr("t4");
    chk("t4_stall", (wrc_q.size() >= 7) ? 32'(wrc_q[6] - wrc_q[5]) : 32'hFFFF_FFFF, 32'd5);
    chk("t4_viol", 32'(viol), 32'd0);

    // FIFO reset after payload byte 2 of 8, full lingers past the reset
    clear_logs();
    start_pkt(0, 16'd8, 8'h40, 8);
    wait_wr("t5", 4);
    tx_reset_i = 1'b1;
    tx_full_i  = 1'b1;
    repeat (2) @(posedge clk_i);
    #2 tx_reset_i = 1'b0;
    chk("t5_grant", 32'(grant_o), 32'd0);
    chk("t5_nabort", 32'(abort_q.size()), 32'd1);
    chk("t5_abort", (abort_q.size() > 0) ? 32'(abort_q[0]) : 32'hF, 32'h1);
    start_pkt(1, 16'd1, 8'h55, 1);
    repeat (3) @(posedge clk_i);
    chk("t5_hold", 32'(wr_q.size()), 32'd4);
    #2 tx_full_i = 1'b0;
    wait_idle("t5");
    exp_q.push_back(8'h00); exp_q.push_back(8'h08);
    exp_q.push_back(8'h40); exp_q.push_back(8'h41);
    exp_pkt(16'd1, 8'h55, 1);
    cmp_wr("t5");
    chk("t5_ndone", 32'(done_q.size()), 32'd1);
`ifdef ETH_TX_SCHED_STATS_EN
    chk("t5_stat_pkts", stat_pkts_o, 32'd8);
    chk("t5_stat_aborts", 32'(stat_aborts_o), 32'd1);
`endif

    // Asynchronous reset in the middle of DATA
    clear_logs();
    start_pkt(0, 16'd6, 8'h60, 6);
    wait_wr("t6", 4);
    chk("t6_pre_grant", 32'(grant_o), 32'd1);
    rst_i = 1'b1;
    #1;
    chk("t6_grant", 32'(grant_o), 32'd0);
    chk("t6_wren", 32'(tx_wr_en_o), 32'd0);
    chk("t6_ready", 32'(data_ready_o), 32'd0);
    chk("t6_data", 32'(tx_data_o), 32'd0);
    chk("t6_pulses", 32'({done_o, err_o, abort_o}), 32'd0);
`ifdef ETH_TX_SCHED_STATS_EN
    chk("t6_stat_pkts", stat_pkts_o, 32'd0);
    chk("t6_stat_aborts", 32'(stat_aborts_o), 32'd0);
`endif
    drop(0); drop(1);
    @(posedge clk_i);
    #2 rst_i = 1'b0;
    clear_logs();
    sync();
    start_pkt(1, 16'd1, 8'h77, 1);
    wait_idle("t6");
    exp_pkt(16'd1, 8'h77, 1);
    cmp_wr("t6");
    chk("t6_done", (done_q.size() > 0) ? 32'(done_q[0]) : 32'hF, 32'h2);
    chk("final_viol", 32'(viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
